// File: rtl/seq_gen_pkg.sv
// Shared state encoding and default widths for the serial pattern generator.
package seq_gen_pkg;

  localparam int SEQ_PAT_W = 4;
  localparam int SEQ_CNT_W = 8;
  localparam int SEQ_GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// MSB-first load/shift register with bit index; out bit and active flag come straight from flops.
module seq_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_val,
  output logic             bit_out,
  output logic             active,
  output logic             last_bit
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] data;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      data   <= load_val;
      idx    <= IDX_W'(PAT_W - 1);
      active <= 1'b1;
    end else if (clear) begin
      // Zeroing the data keeps the serial line low whenever nothing is valid.
      data   <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (shift) begin
      data <= {data[PAT_W-2:0], 1'b0};
      idx  <= idx - IDX_W'(1);
    end
  end

  assign bit_out  = data[PAT_W-1];
  assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats a PAT_W-bit pattern MSB first with an idle gap between repetitions.
// Optional abort input enabled by defining SEQ_PATTERN_GEN_ABORT_EN.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = SEQ_CNT_W,
  parameter int GAP_W = SEQ_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_PATTERN_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  state_t           state, next_state;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic             abort_w, accept, last_rep;
  logic             sr_load, sr_clear, sr_shift, sr_last;
  logic [PAT_W-1:0] sr_val;
  logic             busy_nxt, done_nxt;

`ifdef SEQ_PATTERN_GEN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept   = (state == IDLE) && start;
  assign last_rep = (sent_cnt == rep_q - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = (repeat_cnt == '0) ? DONE : SHIFT;
      SHIFT: begin
        if (abort_w)                  next_state = DONE;
        else if (sr_last && last_rep) next_state = DONE;
        else if (sr_last && gap_q != '0) next_state = GAP;
      end
      GAP: begin
        if (abort_w)                  next_state = DONE;
        else if (gap_cnt == GAP_W'(1)) next_state = SHIFT;
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (next_state == SHIFT) || (next_state == GAP);
    done_nxt = (next_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Reload at the start of every repetition; first one comes straight from the input port.
  always_comb begin
    sr_load  = (next_state == SHIFT) && ((state != SHIFT) || sr_last);
    sr_clear = (next_state != SHIFT);
    sr_shift = (state == SHIFT);
    sr_val   = (state == IDLE) ? pattern : pat_q;
  end

  seq_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .clear    (sr_clear),
    .shift    (sr_shift),
    .load_val (sr_val),
    .bit_out  (out),
    .active   (out_valid),
    .last_bit (sr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      sent_cnt <= '0;
    end else begin
      if (accept) begin
        pat_q    <= pattern;
        rep_q    <= repeat_cnt;
        gap_q    <= gap_len;
        sent_cnt <= '0;
      end else if ((state == SHIFT) && sr_last && !abort_w) begin
        sent_cnt <= sent_cnt + CNT_W'(1);
      end
      if ((state == SHIFT) && (next_state == GAP)) gap_cnt <= gap_q;
      else if (state == GAP)                       gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen, including a closed loop through an overlapping 1101 detector.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       out, out_valid, busy, done;
  logic [7:0] sent_cnt;
`ifdef SEQ_PATTERN_GEN_ABORT_EN
  logic       abort;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   oz_err = 0;
  int   hits = 0;
  bit   exp_q[$];
  bit   obs_q[$];
  logic [2:0] det;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
`ifdef SEQ_PATTERN_GEN_ABORT_EN
    .abort      (abort),
`endif
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt)
  );

  // Moore overlapping 1101 detector; state 4 means a hit.
  always @(posedge clk or posedge rst) begin
    if (rst) det <= 3'd0;
    else begin
      case (det)
        3'd0: det <= out ? 3'd1 : 3'd0;
        3'd1: det <= out ? 3'd2 : 3'd0;
        3'd2: det <= out ? 3'd2 : 3'd3;
        3'd3: det <= out ? 3'd4 : 3'd0;
        3'd4: det <= out ? 3'd2 : 3'd0;
        default: det <= 3'd0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) obs_q.push_back(out);
      else if (out) oz_err++;
      if (det == 3'd4) hits++;
    end
  end

  task automatic start_tx(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g,
                          input int full_reps);
    @(negedge clk);
    pattern = p; repeat_cnt = r; gap_len = g; start = 1'b1;
    for (int i = 0; i < full_reps; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(p[b]);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output logic busy1);
    cyc = -1;
    busy1 = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = busy;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0; gap_len = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out !== 1'b0)       begin n_bad++; $display("FAIL reset_out got %b want 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sent_cnt !== 8'd0)  begin n_bad++; $display("FAIL reset_sent got %0d want 0", sent_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; logic b1; bit e, o; int oz0;
    oz0 = oz_err; exp_q.delete(); obs_q.delete();
    start_tx(4'b1101, 8'd1, 4'd0, 1);
    wait_done(30, cyc, b1);
    n_cmp++; if (cyc !== 5)          begin n_bad++; $display("FAIL basic_done_cycle got %0d want 5", cyc); end
    n_cmp++; if (b1 !== 1'b1)        begin n_bad++; $display("FAIL basic_busy got %b want 1", b1); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    n_cmp++; if (sent_cnt !== 8'd1)  begin n_bad++; $display("FAIL basic_sent got %0d want 1", sent_cnt); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    n_cmp++; if (sent_cnt !== 8'd1)  begin n_bad++; $display("FAIL basic_sent_hold got %0d want 1", sent_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL basic_bit got %b want %b", o, e); end
    end
    n_cmp++; if (oz_err != oz0) begin n_bad++; $display("FAIL basic_out_idle got %0d want %0d", oz_err, oz0); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic b1; bit e, o;
    exp_q.delete(); obs_q.delete();
    start_tx(4'b1011, 8'd3, 4'd0, 3);
    wait_done(40, cyc, b1);
    n_cmp++; if (cyc !== 13)         begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 13", cyc); end
    n_cmp++; if (sent_cnt !== 8'd3)  begin n_bad++; $display("FAIL b2b_sent got %0d want 3", sent_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_bit got %b want %b", o, e); end
    end
  endtask

  task automatic test_gapped();
    int cyc; logic b1; bit e, o; int oz0;
    oz0 = oz_err; exp_q.delete(); obs_q.delete();
    start_tx(4'b1101, 8'd2, 4'd3, 2);
    wait_done(40, cyc, b1);
    n_cmp++; if (cyc !== 12)         begin n_bad++; $display("FAIL gap_done_cycle got %0d want 12", cyc); end
    n_cmp++; if (sent_cnt !== 8'd2)  begin n_bad++; $display("FAIL gap_sent got %0d want 2", sent_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gap_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL gap_bit got %b want %b", o, e); end
    end
    n_cmp++; if (oz_err != oz0) begin n_bad++; $display("FAIL gap_out_idle got %0d want %0d", oz_err, oz0); end
  endtask

  task automatic test_zero_and_busy_start();
    int cyc; logic b1; logic bmid; bit e, o;
    exp_q.delete(); obs_q.delete();
    start_tx(4'b1111, 8'd0, 4'd2, 0);
    wait_done(10, cyc, b1);
    n_cmp++; if (cyc !== 1)          begin n_bad++; $display("FAIL zero_done_cycle got %0d want 1", cyc); end
    n_cmp++; if (sent_cnt !== 8'd0)  begin n_bad++; $display("FAIL zero_sent got %0d want 0", sent_cnt); end
    n_cmp++; if (b1 !== 1'b0)        begin n_bad++; $display("FAIL zero_busy got %b want 0", b1); end
    @(negedge clk);
    n_cmp++; if (obs_q.size() != 0)  begin n_bad++; $display("FAIL zero_valid got %0d want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
    bmid = 1'b0;
    start_tx(4'b1011, 8'd2, 4'd0, 2);
    fork
      wait_done(40, cyc, b1);
      begin
        repeat (3) @(negedge clk);
        bmid = busy;
        pattern = 4'b0100; repeat_cnt = 8'd5; gap_len = 4'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    n_cmp++; if (bmid !== 1'b1)      begin n_bad++; $display("FAIL busy_mid got %b want 1", bmid); end
    n_cmp++; if (cyc !== 9)          begin n_bad++; $display("FAIL busy_done_cycle got %0d want 9", cyc); end
    n_cmp++; if (sent_cnt !== 8'd2)  begin n_bad++; $display("FAIL busy_sent got %0d want 2", sent_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL busy_bit got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic b1; bit e, o;
    exp_q.delete(); obs_q.delete();
    start_tx(4'b1101, 8'd2, 4'd0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out !== 1'b0)       begin n_bad++; $display("FAIL rmid_out got %b want 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (sent_cnt !== 8'd0)  begin n_bad++; $display("FAIL rmid_sent got %0d want 0", sent_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    start_tx(4'b1011, 8'd1, 4'd0, 1);
    wait_done(30, cyc, b1);
    n_cmp++; if (cyc !== 5)          begin n_bad++; $display("FAIL rmid_done_cycle got %0d want 5", cyc); end
    n_cmp++; if (sent_cnt !== 8'd1)  begin n_bad++; $display("FAIL rmid_sent_after got %0d want 1", sent_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rmid_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rmid_bit got %b want %b", o, e); end
    end
  endtask

  task automatic test_closed_loop();
    int cyc; logic b1; int h0; bit e, o;
    exp_q.delete(); obs_q.delete();
    repeat (3) @(negedge clk);
    h0 = hits;
    start_tx(4'b1101, 8'd4, 4'd0, 4);
    wait_done(40, cyc, b1);
    n_cmp++; if (cyc !== 17)         begin n_bad++; $display("FAIL loop_done_cycle got %0d want 17", cyc); end
    n_cmp++; if (sent_cnt !== 8'd4)  begin n_bad++; $display("FAIL loop_sent got %0d want 4", sent_cnt); end
    repeat (4) @(negedge clk);
    n_cmp++; if (hits - h0 != 4)     begin n_bad++; $display("FAIL loop_hits got %0d want 4", hits - h0); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL loop_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL loop_bit got %b want %b", o, e); end
    end
  endtask

`ifdef SEQ_PATTERN_GEN_ABORT_EN
  task automatic test_abort();
    int cyc; logic b1; bit e, o;
    exp_q.delete(); obs_q.delete();
    start_tx(4'b1101, 8'd4, 4'd0, 2);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    fork
      wait_done(40, cyc, b1);
      begin
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
    join
    n_cmp++; if (cyc !== 11)         begin n_bad++; $display("FAIL abort_done_cycle got %0d want 11", cyc); end
    n_cmp++; if (sent_cnt !== 8'd2)  begin n_bad++; $display("FAIL abort_sent got %0d want 2", sent_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL abort_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL abort_bit got %b want %b", o, e); end
    end
  endtask
`endif

  initial begin
`ifdef SEQ_PATTERN_GEN_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_zero_and_busy_start();
    test_reset_mid();
    test_closed_loop();
`ifdef SEQ_PATTERN_GEN_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
